// File: rtl/uart_pkg.sv
// Shared UART types and helpers: transmit state encoding, LCR word-length
// codes and the latched frame configuration used by the TX sequencer.
package uart_pkg;

  localparam int OVERSAMPLE_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } tx_state_e;

  localparam logic [1:0] WL_5 = 2'b00;
  localparam logic [1:0] WL_6 = 2'b01;
  localparam logic [1:0] WL_7 = 2'b10;
  localparam logic [1:0] WL_8 = 2'b11;

  typedef struct packed {
    logic [1:0] wl;
    logic       stop2;
    logic       par_en;
    logic       even;
    logic       stick;
  } frame_cfg_t;

  function automatic logic [3:0] wl_to_bits(input logic [1:0] wl);
    logic [3:0] n;
    case (wl)
      WL_5:    n = 4'd5;
      WL_6:    n = 4'd6;
      WL_7:    n = 4'd7;
      default: n = 4'd8;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Baud-tick counter that flags the end of a full or half bit period.
// Shared by the TX and RX sequencers.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
  parameter int CNT_W      = 6
) (
  input  logic clk,
  input  logic reset_n,
  input  logic baud_tick_i,
  input  logic clear_i,
  input  logic half_i,
  output logic bit_end_o
);

  localparam logic [CNT_W-1:0] FULL_END = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(OVERSAMPLE / 2 - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] end_cnt;

  assign end_cnt   = half_i ? HALF_END : FULL_END;
  assign bit_end_o = baud_tick_i && !clear_i && (cnt_q == end_cnt);

  // Clear wins over a coincident tick so a period always restarts from zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (baud_tick_i) begin
      cnt_q <= bit_end_o ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: pops bytes from the show-ahead TX FIFO and
// serialises start, data (LSB first), optional parity and stop bits.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
  parameter int CNT_W      = 6
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       baud_tick_i,
  input  logic [1:0] data_bits_i,
  input  logic       stop_bits_i,
  input  logic       parity_en_i,
  input  logic       even_parity_i,
  input  logic       stick_parity_i,
  input  logic       break_i,
  input  logic       fifo_empty_i,
  input  logic [7:0] fifo_data_i,
  output logic       fifo_rd_o,
  output logic       tx_o,
  output logic       tx_busy_o,
  output logic       tx_empty_o,
  output logic       frame_done_o
);

  tx_state_e  state_q;
  tx_state_e  state_d;
  frame_cfg_t cfg_q;
  logic [7:0] shift_q;
  logic [2:0] bit_cnt_q;
  logic       par_acc_q;
  logic       stop_ext_q;
  logic       tx_q;
  logic       fifo_rd_q;
  logic       frame_done_q;

  logic       bit_end;
  logic       tmr_clear;
  logic       tmr_half;
  logic       last_data;
  logic       stop_last;
  logic       stop_end;
  logic       line_d;

  function automatic logic parity_bit(input frame_cfg_t cfg, input logic acc);
    if (cfg.stick) begin
      return ~cfg.even;
    end
    return cfg.even ? acc : ~acc;
  endfunction

  uart_bit_timer #(
    .OVERSAMPLE (OVERSAMPLE),
    .CNT_W      (CNT_W)
  ) u_bit_timer (
    .clk         (clk),
    .reset_n     (reset_n),
    .baud_tick_i (baud_tick_i),
    .clear_i     (tmr_clear),
    .half_i      (tmr_half),
    .bit_end_o   (bit_end)
  );

  // The second stop period is only half long for 5-bit words.
  always_comb begin
    tmr_clear = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    tmr_half  = (state_q == ST_STOP) && stop_ext_q && (cfg_q.wl == WL_5);
    last_data = ({1'b0, bit_cnt_q} == (wl_to_bits(cfg_q.wl) - 4'd1));
    stop_last = !cfg_q.stop2 || stop_ext_q;
    stop_end  = (state_q == ST_STOP) && bit_end && stop_last;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (!fifo_empty_i) state_d = ST_LOAD;
      ST_LOAD:   state_d = ST_START;
      ST_START:  if (bit_end) state_d = ST_DATA;
      ST_DATA: begin
        if (bit_end && last_data) begin
          state_d = cfg_q.par_en ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: if (bit_end) state_d = ST_STOP;
      ST_STOP: begin
        if (stop_end) begin
          state_d = fifo_empty_i ? ST_IDLE : ST_LOAD;
        end
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    line_d = 1'b1;
    case (state_q)
      ST_START:  line_d = 1'b0;
      ST_DATA:   line_d = shift_q[0];
      ST_PARITY: line_d = parity_bit(cfg_q, par_acc_q);
      default:   line_d = 1'b1;
    endcase
  end

  // Frame datapath: byte and LCR are captured together so later LCR writes
  // only take effect at the next LOAD.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      cfg_q      <= '0;
      par_acc_q  <= 1'b0;
      stop_ext_q <= 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          shift_q    <= fifo_data_i;
          cfg_q      <= {data_bits_i, stop_bits_i, parity_en_i,
                         even_parity_i, stick_parity_i};
          bit_cnt_q  <= '0;
          par_acc_q  <= 1'b0;
          stop_ext_q <= 1'b0;
        end
        ST_START: begin
          if (bit_end) bit_cnt_q <= '0;
        end
        ST_DATA: begin
          if (bit_end) begin
            par_acc_q <= par_acc_q ^ shift_q[0];
            shift_q   <= {1'b0, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
          end
        end
        ST_STOP: begin
          if (bit_end) stop_ext_q <= !stop_last;
        end
        default: ;
      endcase
    end
  end

  // Registered outputs: the line follows the state one cycle later and the
  // pop strobe covers exactly the LOAD cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_q         <= 1'b1;
      fifo_rd_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      tx_q         <= break_i ? 1'b0 : line_d;
      fifo_rd_q    <= (state_d == ST_LOAD);
      frame_done_q <= stop_end;
    end
  end

  assign tx_o         = tx_q;
  assign fifo_rd_o    = fifo_rd_q;
  assign frame_done_o = frame_done_q;
  assign tx_busy_o    = (state_q != ST_IDLE);
  assign tx_empty_o   = (state_q == ST_IDLE) && fifo_empty_i;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Randomised bench for uart_tx_ctrl with a frame-level reference model.
module tb_uart_tx_ctrl;

  localparam int OS = 16;

  typedef struct packed {
    logic [11:0] lv;
    int          n;
    int          last_len;
  } frame_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       baud_tick_i = 1'b0;
  logic [1:0] data_bits_i = 2'b11;
  logic       stop_bits_i = 1'b0;
  logic       parity_en_i = 1'b0;
  logic       even_parity_i = 1'b0;
  logic       stick_parity_i = 1'b0;
  logic       break_i = 1'b0;
  logic       fifo_empty_i = 1'b1;
  logic [7:0] fifo_data_i = 8'h00;
  logic       fifo_rd_o;
  logic       tx_o;
  logic       tx_busy_o;
  logic       tx_empty_o;
  logic       frame_done_o;

  uart_tx_ctrl #(.OVERSAMPLE(OS), .CNT_W(6)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .baud_tick_i    (baud_tick_i),
    .data_bits_i    (data_bits_i),
    .stop_bits_i    (stop_bits_i),
    .parity_en_i    (parity_en_i),
    .even_parity_i  (even_parity_i),
    .stick_parity_i (stick_parity_i),
    .break_i        (break_i),
    .fifo_empty_i   (fifo_empty_i),
    .fifo_data_i    (fifo_data_i),
    .fifo_rd_o      (fifo_rd_o),
    .tx_o           (tx_o),
    .tx_busy_o      (tx_busy_o),
    .tx_empty_o     (tx_empty_o),
    .frame_done_o   (frame_done_o)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         fails = 0;
  int         cyc = 0;
  logic [7:0] fifo_q[$];
  logic       pop_pending = 1'b0;
  int         gap = 0;
  int         tick_cnt = 0;
  int         last_ticks = 0;
  int         done_cnt = 0;
  int         rd_cnt = 0;
  int         exp_done = 0;
  logic       brk_mon = 1'b0;
  int         brk_ones = 0;

  // Reference model: phase 0 idle, 1 load, 2 frame on the line.
  int         m_ph = 0;
  int         m_idx = 0;
  int         m_tk = 0;
  frame_t     m_fr = '0;
  logic       m_tx = 1'b1;
  logic       m_rd = 1'b0;
  logic       m_done = 1'b0;

  // Level of every bit period in the frame; the final stop may be half long.
  function automatic frame_t mk_frame(input logic [7:0] b, input logic [1:0] wl,
                                      input logic sb, input logic pe,
                                      input logic ep, input logic sp);
    frame_t f;
    int nd;
    int ones;
    int k;
    f = '0;
    nd = 5 + int'(wl);
    ones = 0;
    f.lv[0] = 1'b0;
    k = 1;
    for (int i = 0; i < nd; i++) begin
      f.lv[k] = b[i];
      ones += int'(b[i]);
      k++;
    end
    if (pe) begin
      if (sp) f.lv[k] = ~ep;
      else if (ep) f.lv[k] = ((ones % 2) == 1);
      else f.lv[k] = ((ones % 2) == 0);
      k++;
    end
    f.lv[k] = 1'b1;
    k++;
    f.last_len = OS;
    if (sb) begin
      f.lv[k] = 1'b1;
      k++;
      f.last_len = (nd == 5) ? OS / 2 : OS;
    end
    f.n = k;
    return f;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = 0;
    m_idx = 0;
    m_tk = 0;
    m_tx = 1'b1;
    m_rd = 1'b0;
    m_done = 1'b0;
  endtask

  task automatic model_step();
    int len;
    logic level;
    if (!reset_n) begin
      model_reset();
      return;
    end
    level = (m_ph == 2) ? m_fr.lv[m_idx] : 1'b1;
    m_tx = break_i ? 1'b0 : level;
    m_done = 1'b0;
    case (m_ph)
      0: if (!fifo_empty_i) m_ph = 1;
      1: begin
        m_fr = mk_frame(fifo_data_i, data_bits_i, stop_bits_i, parity_en_i,
                        even_parity_i, stick_parity_i);
        m_idx = 0;
        m_tk = 0;
        m_ph = 2;
      end
      default: begin
        if (baud_tick_i) begin
          m_tk++;
          len = (m_idx == m_fr.n - 1) ? m_fr.last_len : OS;
          if (m_tk == len) begin
            m_tk = 0;
            m_idx++;
            if (m_idx == m_fr.n) begin
              m_done = 1'b1;
              m_ph = fifo_empty_i ? 0 : 1;
            end
          end
        end
      end
    endcase
    m_rd = (m_ph == 1);
  endtask

  // One clock: model follows the edge, outputs are compared and the next
  // inputs driven at the falling edge.
  task automatic cycle();
    logic [4:0] got;
    logic [4:0] exp;
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    got = {tx_o, fifo_rd_o, frame_done_o, tx_busy_o, tx_empty_o};
    exp = {m_tx, m_rd, m_done, (m_ph != 0), (m_ph == 0) && fifo_empty_i};
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL cycle%0d {tx,rd,done,busy,empty}: got %b expected %b", cyc, got, exp);
    end
    if (brk_mon && tx_o) brk_ones++;
    if (pop_pending && fifo_q.size() > 0) void'(fifo_q.pop_front());
    pop_pending = fifo_rd_o;
    if (frame_done_o) begin
      done_cnt++;
      last_ticks = tick_cnt;
    end
    if (fifo_rd_o) begin
      rd_cnt++;
      tick_cnt = 0;
    end
    if (gap == 0) begin
      baud_tick_i = 1'b1;
      gap = int'($urandom_range(3, 1));
    end else begin
      baud_tick_i = 1'b0;
      gap--;
    end
    if (baud_tick_i && !fifo_rd_o) tick_cnt++;
    fifo_empty_i = (fifo_q.size() == 0);
    fifo_data_i = (fifo_q.size() == 0) ? 8'($urandom) : fifo_q[0];
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int c;
    c = 0;
    while (done_cnt < target && c < budget) begin
      cycle();
      c++;
    end
    check({name, "_done_count"}, done_cnt, target);
  endtask

  task automatic wait_ticks(input int rd_target, input int n, input int budget);
    int c;
    c = 0;
    while ((rd_cnt < rd_target || tick_cnt < n) && c < budget) begin
      cycle();
      c++;
    end
    check("wait_ticks_reached", int'(rd_cnt >= rd_target && tick_cnt >= n), 1);
  endtask

  task automatic set_lcr(input logic [1:0] wl, input logic sb, input logic pe,
                         input logic ep, input logic sp);
    data_bits_i = wl;
    stop_bits_i = sb;
    parity_en_i = pe;
    even_parity_i = ep;
    stick_parity_i = sp;
  endtask

  initial begin
    frame_t f;
    int rd_base;
    int nb;

    f = mk_frame(8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    check("model_8N1_55_levels", int'(f.lv), 12'h2AA);
    check("model_8N1_55_periods", f.n, 10);
    f = mk_frame(8'hA3, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
    check("model_7E1_A3_levels", int'(f.lv), 12'h346);
    f = mk_frame(8'h1F, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    check("model_5O15_1F_levels", int'(f.lv), 12'h1BE);
    check("model_5O15_ticks", (f.n - 1) * OS + f.last_len, 136);

    repeat (3) cycle();
    check("reset_tx", int'(tx_o), 1);
    check("reset_rd", int'(fifo_rd_o), 0);
    check("reset_busy", int'(tx_busy_o), 0);
    check("reset_empty", int'(tx_empty_o), 1);
    reset_n = 1'b1;
    repeat (3) cycle();

    set_lcr(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    fifo_q.push_back(8'h55);
    exp_done++;
    rd_base = rd_cnt;
    wait_done(exp_done, 2000, "8N1_55");
    check("8N1_55_ticks", last_ticks, 160);
    check("8N1_55_pops", rd_cnt - rd_base, 1);

    set_lcr(2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
    fifo_q.push_back(8'hA3);
    exp_done++;
    wait_done(exp_done, 2000, "7E1_A3");
    check("7E1_A3_ticks", last_ticks, 160);

    set_lcr(2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    fifo_q.push_back(8'h1F);
    exp_done++;
    wait_done(exp_done, 2000, "5O15_1F");
    check("5O15_1F_ticks", last_ticks, 136);

    set_lcr(2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
    fifo_q.push_back(8'h3C);
    fifo_q.push_back(8'hC3);
    fifo_q.push_back(8'h81);
    exp_done += 3;
    rd_base = rd_cnt;
    wait_done(exp_done, 6000, "8O2_burst");
    check("8O2_burst_pops", rd_cnt - rd_base, 3);
    check("8O2_burst_ticks", last_ticks, 192);
    check("8O2_burst_tx_empty", int'(tx_empty_o), 1);

    set_lcr(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    fifo_q.push_back(8'hFF);
    fifo_q.push_back(8'h13);
    exp_done += 2;
    wait_ticks(rd_cnt + 1, 50, 2000);
    set_lcr(2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    wait_done(exp_done - 1, 2000, "lcr_change_old");
    check("lcr_change_old_ticks", last_ticks, 160);
    wait_done(exp_done, 2000, "lcr_change_new");
    check("lcr_change_new_ticks", last_ticks, 136);

    set_lcr(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    fifo_q.push_back(8'h55);
    wait_ticks(rd_cnt + 1, 70, 2000);
    check("pre_reset_tx_low", int'(tx_o), 0);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("async_reset_tx", int'(tx_o), 1);
    check("async_reset_rd", int'(fifo_rd_o), 0);
    check("async_reset_busy", int'(tx_busy_o), 0);
    repeat (3) cycle();
    reset_n = 1'b1;
    repeat (2) cycle();
    fifo_q.push_back(8'h55);
    exp_done++;
    wait_done(exp_done, 2000, "post_reset");
    check("post_reset_ticks", last_ticks, 160);

    fifo_q.push_back(8'h5A);
    exp_done++;
    wait_ticks(rd_cnt + 1, 3, 2000);
    break_i = 1'b1;
    brk_mon = 1'b1;
    brk_ones = 0;
    wait_done(exp_done, 2000, "break_frame");
    check("break_tx_high_cycles", brk_ones, 0);
    check("break_frame_ticks", last_ticks, 160);
    break_i = 1'b0;
    brk_mon = 1'b0;
    repeat (3) cycle();
    check("break_release_tx", int'(tx_o), 1);

    for (int r = 0; r < 12; r++) begin
      set_lcr(2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      nb = int'($urandom_range(2, 1));
      for (int j = 0; j < nb; j++) fifo_q.push_back(8'($urandom));
      exp_done += nb;
      wait_done(exp_done, 2500 * nb, "random_frame");
    end
    repeat (5) cycle();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Transmit sequencer for the APB UART. It pops bytes from the show-ahead TX FIFO behind the TDR and serialises each one onto the TX line as a frame: start bit, 5-8 data bits LSB-first, optional parity, then stop bits. Frame format comes from the LCR fields, and bit timing comes from the shared baud-tick generator. It sits between the register file (configuration, FIFO) and the pad.

Parameters:
OVERSAMPLE, 16, baud_tick_i pulses per bit period; legal range 4..32.
CNT_W, 6, tick-counter width; must hold 1.5*OVERSAMPLE.

Ports:
clk  input  1  system clock.
reset_n  input  1  asynchronous active-low reset.
baud_tick_i  input  1  single-cycle pulse at OVERSAMPLE x baud rate.
data_bits_i  input  2  LCR word length: 00=5, 01=6, 10=7, 11=8.
stop_bits_i  input  1  0 = 1 stop bit; 1 = 2 stop bits (1.5 when word length is 5).
parity_en_i  input  1  LCR parity enable.
even_parity_i  input  1  LCR even-parity select.
stick_parity_i  input  1  LCR stick parity.
break_i  input  1  LCR break control.
fifo_empty_i  input  1  TX FIFO empty.
fifo_data_i  input  8  TX FIFO head word (show-ahead).
fifo_rd_o  output  1  one-cycle pop strobe.
tx_o  output  1  serial line, idle high.
tx_busy_o  output  1  a frame is in progress (state != IDLE).
tx_empty_o  output  1  state == IDLE and fifo_empty_i (drives LSR.TEMT).
frame_done_o  output  1  one-cycle pulse on completion of the last stop bit.

Behaviour:
- Reset (async, any state, including mid-frame): state=IDLE; tx_o=1; fifo_rd_o=0; frame_done_o=0; tick counter=0; bit counter=0; shift register=0. A partial frame is abandoned, never resumed.
- States: IDLE, LOAD, START, DATA, PARITY, STOP.
- IDLE: tx_o=1. When fifo_empty_i=0, go to LOAD on the next edge.
- LOAD (exactly 1 cycle):
  - fifo_rd_o=1.
  - Capture fifo_data_i into the shift register.
  - Latch all LCR fields into a frame-config register.
  - Clear the tick counter.
  - Go to START.
  - LCR changes after LOAD do not affect the current frame.
- Bit timing: the tick counter increments on each baud_tick_i. A bit period ends on the cycle where count == OVERSAMPLE-1 and baud_tick_i=1; the counter then clears.
  - Half-extra stop bit: it ends at count == OVERSAMPLE/2-1.
  - Ticks are never counted in LOAD or IDLE.
- START: tx_o=0 for one bit period, then go to DATA with the bit counter at 0.
- DATA: tx_o = shift register[0]. At the end of each period, shift right and increment the bit counter. After N bits (N = 5..8 from the latched word length), go to PARITY if parity is enabled, else STOP.
- PARITY: one bit period. The parity bit is:
  - stick parity: ~even_parity;
  - even parity: XOR of the N data bits;
  - odd parity: XNOR of the N data bits.
  - Only the N transmitted bits participate; upper bits of the byte are ignored.
- STOP: tx_o=1.
  - Duration: 1 bit period; 2 periods if stop_bits=1 with N>5; 1.5 periods if stop_bits=1 with N=5.
  - At the end: frame_done_o=1 for that cycle. Go to LOAD if fifo_empty_i=0 (back-to-back frames with no idle gap), else IDLE.
- Break: while break_i=1, tx_o is forced to 0 in every state. The state machine keeps running and frames still drain. Releasing break restores normal tx_o on the next cycle.
- tx_o, fifo_rd_o and frame_done_o are registered, so tx_o changes one cycle after the state transition. fifo_rd_o is never asserted when fifo_empty_i=0 was not seen in the preceding IDLE/STOP decision.
- A baud_tick_i coincident with the LOAD cycle is ignored.

Decomposition:
- Shared package uart_pkg:
  - tx_state_e enum;
  - word-length encoding constants (WL_5..WL_8);
  - function wl_to_bits() mapping the 2-bit code to 5..8;
  - OVERSAMPLE default constant.
- Sub-module uart_bit_timer: holds the tick counter. Inputs: clear, half/full select. Output: bit_end strobe. Reusable by the RX side.
- Parity computation and frame-config register stay inline.

Test Plan:
- 8N1, byte 0x55, OVERSAMPLE=16 -> tx_o sequence 0,1,0,1,0,1,0,1,0,1, each bit held for exactly 16 ticks. One fifo_rd_o pulse. frame_done_o pulses once, 160 ticks after START entry.
- 7E1, byte 0xA3 -> data 1,1,0,0,0,1,0 (bit 7 dropped), parity bit 1, one stop bit, total 10 bit periods.
- 5 data bits, stop_bits=1, odd parity, byte 0x1F -> parity bit 0; stop held for 24 ticks; total frame 8.5 bit periods.
- FIFO holds 3 bytes at 8O2 -> three frames back-to-back. tx_o never idles between a STOP end and the next START beyond the LOAD cycle plus 1 cycle. Exactly 3 fifo_rd_o pulses, and tx_empty_o rises after the third frame_done_o.
- Change LCR from 8N1 to 5E2 mid-DATA of byte 0xFF -> the current frame completes as 8N1; the next byte uses 5E2.
- reset_n low during the 4th data bit -> tx_o=1 and fifo_rd_o=0 asynchronously. After release, the next frame starts with a full-length start bit. Also: break_i=1 during a frame -> tx_o=0 throughout while frame_done_o still pulses on schedule.
